deserializer: RTL and testbench

- Receive-side counterpart of the FIR filter's bit-serial output path.
- Samples one bit per enabled clock, LSB first, and assembles LENGTH-bit words aligned by a frame-sync strobe.
- Presents each completed word on a valid/ready output with a single holding register.
- Flags overrun and sync misalignment as sticky status bits.

---
 rtl/deserializer.sv | 114 +++++++++++
 tb/tb_deserializer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/deserializer.sv
// Serial-to-parallel receiver: LSB-first bits aligned by a frame-sync strobe
// are assembled into LENGTH-bit words and presented on a single-entry valid/ready output.
module deserializer #(
  parameter int LENGTH = 24
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_din,
  input  logic              i_sync,
  output logic [LENGTH-1:0] ov_dout,
  output logic              o_dout_valid,
  input  logic              i_dout_ready,
  output logic              o_overrun,
  output logic              o_sync_err
);

  // state | meaning
  // IDLE  | no word alignment yet; waiting for i_sync on an enabled cycle
  // SHIFT | aligned; cnt_q holds the index of the next bit to be sampled
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  localparam int CW = (LENGTH > 2) ? $clog2(LENGTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(LENGTH - 1);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  // Holds the LENGTH-1 most recent bits; bit 0 of the word ends up in sr_q[0].
  logic [LENGTH-2:0] sr_q, sr_d;
  logic [LENGTH-1:0] dout_q, dout_d;
  logic              valid_q, valid_d;
  logic              ovr_q, ovr_d;
  logic              serr_q, serr_d;

  logic [LENGTH-1:0] word;
  logic              complete;
  logic              slot_free;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    dout_d    = dout_q;
    valid_d   = valid_q;
    ovr_d     = ovr_q;
    serr_d    = serr_q;
    complete  = 1'b0;
    word      = {i_din, sr_q};
    slot_free = !valid_q || i_dout_ready;

    if (i_en) begin
      unique case (state_q)
        IDLE: begin
          if (i_sync) begin
            sr_d    = word[LENGTH-1:1];
            cnt_d   = CW'(1);
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          sr_d = word[LENGTH-1:1];
          if (i_sync && (cnt_q != '0)) begin
            // Misaligned sync: drop the partial word and restart at bit 0.
            cnt_d  = CW'(1);
            serr_d = 1'b1;
          end else if (cnt_q == LAST) begin
            complete = 1'b1;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (complete) begin
      if (slot_free) begin
        dout_d  = word;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && i_dout_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      serr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      serr_q  <= serr_d;
    end
  end

  assign ov_dout      = dout_q;
  assign o_dout_valid = valid_q;
  assign o_overrun    = ovr_q;
  assign o_sync_err   = serr_q;

endmodule

// File: tb/tb_deserializer.sv
// Self-checking bench for deserializer: directed scenarios plus random traffic,
// every cycle compared against a bit-accumulating reference model.
module tb_deserializer;

  localparam int LENGTH = 24;

  logic              i_clk;
  logic              i_rst_n;
  logic              i_en;
  logic              i_din;
  logic              i_sync;
  logic [LENGTH-1:0] ov_dout;
  logic              o_dout_valid;
  logic              i_dout_ready;
  logic              o_overrun;
  logic              o_sync_err;

  int tests_run = 0;
  int tests_failed = 0;

  deserializer #(.LENGTH(LENGTH)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_en         (i_en),
    .i_din        (i_din),
    .i_sync       (i_sync),
    .ov_dout      (ov_dout),
    .o_dout_valid (o_dout_valid),
    .i_dout_ready (i_dout_ready),
    .o_overrun    (o_overrun),
    .o_sync_err   (o_sync_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference model: accumulates bits arithmetically by index since the last sync.
  bit          m_aligned;
  int          m_idx;
  logic [63:0] m_acc;
  logic [63:0] m_dout;
  bit          m_valid;
  bit          m_ovr;
  bit          m_serr;

  function automatic void model_reset();
    m_aligned = 0;
    m_idx     = 0;
    m_acc     = '0;
    m_dout    = '0;
    m_valid   = 0;
    m_ovr     = 0;
    m_serr    = 0;
  endfunction

  function automatic void model_step(input bit en, input bit din, input bit sync, input bit rdy);
    bit          done;
    logic [63:0] w;
    done = 0;
    w    = '0;
    if (en) begin
      if (sync) begin
        if (m_aligned && m_idx != 0) m_serr = 1;
        m_acc     = 64'(din);
        m_idx     = 1;
        m_aligned = 1;
      end else if (m_aligned) begin
        m_acc = m_acc | (64'(din) << m_idx);
        m_idx = m_idx + 1;
      end
      if (m_aligned && m_idx == LENGTH) begin
        done  = 1;
        w     = m_acc;
        m_idx = 0;
        m_acc = '0;
      end
    end
    if (done) begin
      if (!m_valid || rdy) begin
        m_dout  = w;
        m_valid = 1;
      end else begin
        m_ovr = 1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("dout",     64'(ov_dout),     m_dout);
    chk("valid",    64'(o_dout_valid), 64'(m_valid));
    chk("overrun",  64'(o_overrun),   64'(m_ovr));
    chk("sync_err", 64'(o_sync_err),  64'(m_serr));
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step(input bit en, input bit din, input bit sync, input bit rdy);
    i_en = en; i_din = din; i_sync = sync; i_dout_ready = rdy;
    @(posedge i_clk);
    model_step(en, din, sync, rdy);
    #1;
    check_model();
    @(negedge i_clk);
  endtask

  task automatic do_reset();
    #2 i_rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_dout",  64'(ov_dout), 64'd0);
    chk("rst_valid", 64'(o_dout_valid), 64'd0);
    chk("rst_flags", 64'({o_overrun, o_sync_err}), 64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic send_bits(input logic [63:0] w, input int n, input bit first_sync,
                           input bit rdy, input bit rdy_last, input bit gate);
    logic [63:0] tmp;
    tmp = w;
    for (int i = 0; i < n; i++) begin
      step(1'b1, tmp[i], first_sync && (i == 0), (i == n - 1) ? rdy_last : rdy);
      if (gate) step(1'b0, 1'($urandom), 1'($urandom), rdy);
    end
  endtask

  initial begin
    i_rst_n = 1'b1; i_en = 0; i_din = 0; i_sync = 0; i_dout_ready = 0;
    @(negedge i_clk);
    do_reset();
    step(0, 0, 0, 0);

    // Basic word
    send_bits(64'hA5C3F1, LENGTH, 1, 1, 1, 0);
    chk("basic_valid", 64'(o_dout_valid), 64'd1);
    chk("basic_dout",  64'(ov_dout), 64'hA5C3F1);
    step(1, 0, 0, 1);
    chk("basic_pulse", 64'(o_dout_valid), 64'd0);
    chk("basic_flags", 64'({o_overrun, o_sync_err}), 64'd0);

    // Back-to-back words with gated enable, no second sync
    do_reset();
    send_bits(64'h123456, LENGTH, 1, 1, 1, 1);
    chk("b2b_w1", 64'(ov_dout), 64'h123456);
    send_bits(64'hFEDCBA, LENGTH, 0, 1, 1, 1);
    chk("b2b_w2", 64'(ov_dout), 64'hFEDCBA);

    // Stall and overrun
    do_reset();
    send_bits(64'h000001, LENGTH, 1, 0, 0, 0);
    chk("stall_ovr0", 64'(o_overrun), 64'd0);
    send_bits(64'h000002, LENGTH, 0, 0, 0, 0);
    chk("stall_ovr1", 64'(o_overrun), 64'd1);
    send_bits(64'h000003, LENGTH, 0, 0, 0, 0);
    chk("stall_dout", 64'(ov_dout), 64'h000001);
    chk("stall_valid", 64'(o_dout_valid), 64'd1);
    step(0, 0, 0, 1);
    chk("stall_drain", 64'(o_dout_valid), 64'd0);

    // Simultaneous consume and complete
    do_reset();
    send_bits(64'h00ABCD, LENGTH, 1, 0, 0, 0);
    send_bits(64'h654321, LENGTH, 0, 0, 1, 0);
    chk("simul_valid", 64'(o_dout_valid), 64'd1);
    chk("simul_dout",  64'(ov_dout), 64'h654321);
    chk("simul_ovr",   64'(o_overrun), 64'd0);

    // Resync at bit 10
    do_reset();
    send_bits(64'h3C3C3C, 10, 1, 1, 1, 0);
    send_bits(64'h0F0F0F, LENGTH, 1, 0, 0, 0);
    chk("resync_err",  64'(o_sync_err), 64'd1);
    chk("resync_dout", 64'(ov_dout), 64'h0F0F0F);

    // Async reset mid-word (valid is still held from above)
    send_bits(64'h777777, 12, 0, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 2 * LENGTH; i++) step(1, 1'($urandom), 0, 1);
    chk("postrst_valid", 64'(o_dout_valid), 64'd0);

    // Random traffic
    do_reset();
    step(1, 1'($urandom), 1, 1'($urandom));
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 9) < 7), 1'($urandom),
           ($urandom_range(0, 99) < 2), 1'($urandom));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
